// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared RV32 decode definitions: base opcodes, the immediate-format select
// encoding, the packed control bundle carried by every decoded instruction,
// the decode-stage buffer states and the canonical NOP encoding.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  typedef struct packed {
    immsrc_e    immsrc;
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic [1:0] aluop;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = '0;

  // Buffer occupancy: number of held instructions.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } dec_state_e;

endpackage

// File: rtl/maindec.sv
// maindec
// Combinational opcode-to-control decoder for the decode stage.
// Optional macro: DECODE_ILLEGAL_TRAP_EN adds illegal_o.
// Ports:
//   opcode_i  [6:0]  instruction opcode field
//   ctrl_o    ctrl_t decoded control bundle (all zero for unknown opcodes)
//   illegal_o 1      opcode is not one of the supported instructions (macro only)
import riscv_pkg::*;

module maindec (
  input  logic [6:0] opcode_i,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic       illegal_o,
`endif
  output ctrl_t      ctrl_o
);

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal;
  assign illegal_o = illegal;
`endif

  always_comb begin
    ctrl_o = CTRL_NONE;
`ifdef DECODE_ILLEGAL_TRAP_EN
    illegal = 1'b0;
`endif
    case (opcode_i)
      OP_LOAD: begin
        ctrl_o.immsrc    = IMM_I;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.resultsrc = 2'b01;
        ctrl_o.aluop     = 2'b00;
      end
      OP_STORE: begin
        ctrl_o.immsrc    = IMM_S;
        ctrl_o.memwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = 2'b00;
      end
      OP_RTYPE: begin
        ctrl_o.immsrc    = IMM_I;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.aluop     = 2'b10;
      end
      OP_BRANCH: begin
        ctrl_o.immsrc    = IMM_B;
        ctrl_o.branch    = 1'b1;
        ctrl_o.aluop     = 2'b01;
      end
      OP_IALU: begin
        ctrl_o.immsrc    = IMM_I;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.alusrc    = 1'b1;
        ctrl_o.aluop     = 2'b10;
      end
      OP_JAL: begin
        ctrl_o.immsrc    = IMM_J;
        ctrl_o.regwrite  = 1'b1;
        ctrl_o.jump      = 1'b1;
        ctrl_o.resultsrc = 2'b10;
      end
      default: begin
        // Unknown opcode: no architectural side effect.
        ctrl_o = CTRL_NONE;
`ifdef DECODE_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// Two-entry in-order skid buffer between fetch and execute. Instructions are
// decoded as they are captured and the controls are stored with the entry, so
// every output comes straight from a register. The head entry drives outputs.
// Optional macro: DECODE_ILLEGAL_TRAP_EN adds the 'illegal' output.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high on that side. in_ready is registered and low only when both entries are
// full; out_valid is high whenever at least one entry is held. Neither ready
// depends combinationally on the other side's valid.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   in_valid/in_ready      fetch-side handshake
//   instr_i, pc_i          fetched instruction and its pc
//   flush                  drop all held and same-cycle incoming instructions
//   out_valid/out_ready    execute-side handshake
//   instr_o, pc_o          head instruction and pc
//   immsrc .. aluop        head decoded controls
//   illegal                head opcode unsupported (macro only)
//   dbg_state_o            buffer state for observation
import riscv_pkg::*;

module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [1:0]      immsrc,
  output logic            regwrite,
  output logic            alusrc,
  output logic            memwrite,
  output logic            branch,
  output logic            jump,
  output logic [1:0]      resultsrc,
  output logic [1:0]      aluop,
`ifdef DECODE_ILLEGAL_TRAP_EN
  output logic            illegal,
`endif
  output logic [1:0]      dbg_state_o
);

  dec_state_e state_q, state_d;
  logic       in_ready_q, in_ready_d;

  logic [31:0]     head_instr_q, head_instr_d, tail_instr_q, tail_instr_d;
  logic [XLEN-1:0] head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
  ctrl_t           head_ctrl_q, head_ctrl_d, tail_ctrl_q, tail_ctrl_d;
  ctrl_t           dec_ctrl;

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
  logic dec_ill;
`endif

  logic accept;
  logic release_w;

  // Decode on the input path so the controls are ready at capture.
  maindec u_maindec (
    .opcode_i  (instr_i[6:0]),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal_o (dec_ill),
`endif
    .ctrl_o    (dec_ctrl)
  );

  assign accept    = in_valid && in_ready_q;
  assign release_w = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d      = state_q;
    head_instr_d = head_instr_q;
    head_pc_d    = head_pc_q;
    head_ctrl_d  = head_ctrl_q;
    tail_instr_d = tail_instr_q;
    tail_pc_d    = tail_pc_q;
    tail_ctrl_d  = tail_ctrl_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
    head_ill_d   = head_ill_q;
    tail_ill_d   = tail_ill_q;
`endif

    if (flush) begin
      // Flush wins over everything, including a same-cycle accept.
      state_d      = ST_EMPTY;
      head_instr_d = INSTR_NOP;
      head_pc_d    = '0;
      head_ctrl_d  = CTRL_NONE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      head_ill_d   = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d      = ST_ONE;
            head_instr_d = instr_i;
            head_pc_d    = pc_i;
            head_ctrl_d  = dec_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
            head_ill_d   = dec_ill;
`endif
          end
        end
        ST_ONE: begin
          if (accept && release_w) begin
            // Head leaves and the new instruction takes its place.
            head_instr_d = instr_i;
            head_pc_d    = pc_i;
            head_ctrl_d  = dec_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
            head_ill_d   = dec_ill;
`endif
          end else if (accept) begin
            state_d      = ST_TWO;
            tail_instr_d = instr_i;
            tail_pc_d    = pc_i;
            tail_ctrl_d  = dec_ctrl;
`ifdef DECODE_ILLEGAL_TRAP_EN
            tail_ill_d   = dec_ill;
`endif
          end else if (release_w) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          // in_ready is low here, so only a release can occur.
          if (release_w) begin
            state_d      = ST_ONE;
            head_instr_d = tail_instr_q;
            head_pc_d    = tail_pc_q;
            head_ctrl_d  = tail_ctrl_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
            head_ill_d   = tail_ill_q;
`endif
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_EMPTY;
      in_ready_q   <= 1'b1;
      head_instr_q <= INSTR_NOP;
      head_pc_q    <= '0;
      head_ctrl_q  <= CTRL_NONE;
      tail_instr_q <= INSTR_NOP;
      tail_pc_q    <= '0;
      tail_ctrl_q  <= CTRL_NONE;
`ifdef DECODE_ILLEGAL_TRAP_EN
      head_ill_q   <= 1'b0;
      tail_ill_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      head_instr_q <= head_instr_d;
      head_pc_q    <= head_pc_d;
      head_ctrl_q  <= head_ctrl_d;
      tail_instr_q <= tail_instr_d;
      tail_pc_q    <= tail_pc_d;
      tail_ctrl_q  <= tail_ctrl_d;
`ifdef DECODE_ILLEGAL_TRAP_EN
      head_ill_q   <= head_ill_d;
      tail_ill_q   <= tail_ill_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = (state_q != ST_EMPTY);
  assign instr_o     = head_instr_q;
  assign pc_o        = head_pc_q;
  assign immsrc      = head_ctrl_q.immsrc;
  assign regwrite    = head_ctrl_q.regwrite;
  assign alusrc      = head_ctrl_q.alusrc;
  assign memwrite    = head_ctrl_q.memwrite;
  assign branch      = head_ctrl_q.branch;
  assign jump        = head_ctrl_q.jump;
  assign resultsrc   = head_ctrl_q.resultsrc;
  assign aluop       = head_ctrl_q.aluop;
  assign dbg_state_o = state_q;
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign illegal     = head_ill_q;
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
// Randomized and directed bench for decode_stage against a queue-based model
// of a two-deep in-order buffer with a table-driven reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr_i = '0;
  logic [31:0] pc_i = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [1:0]  immsrc;
  logic        regwrite, alusrc, memwrite, branch, jump;
  logic [1:0]  resultsrc, aluop;
  logic [1:0]  dbg_state;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  decode_stage #(.XLEN(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr_i     (instr_i),
    .pc_i        (pc_i),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .immsrc      (immsrc),
    .regwrite    (regwrite),
    .alusrc      (alusrc),
    .memwrite    (memwrite),
    .branch      (branch),
    .jump        (jump),
    .resultsrc   (resultsrc),
    .aluop       (aluop),
`ifdef DECODE_ILLEGAL_TRAP_EN
    .illegal     (illegal),
`endif
    .dbg_state_o (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int hs_cnt = 0;
  bit started = 1'b0;
  bit after_reset = 1'b0;

  // Scoreboard: {pc, instr} of each held instruction, oldest first.
  logic [63:0] exp_q[$];

  logic [10:0] dut_ctrl;
  assign dut_ctrl = {immsrc, regwrite, alusrc, memwrite, branch, jump, resultsrc, aluop};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference control table: {immsrc, regwrite, alusrc, memwrite, branch, jump, resultsrc, aluop}
  function automatic logic [10:0] ref_ctrl(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    case (op)
      7'b0000011: return {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00};
      7'b0100011: return {2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00};
      7'b0110011: return {2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      7'b1100011: return {2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01};
      7'b0010011: return {2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10};
      7'b1101111: return {2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00};
      default:    return 11'd0;
    endcase
  endfunction

  function automatic logic ref_illegal(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return !(op == 7'b0000011 || op == 7'b0100011 || op == 7'b0110011 ||
             op == 7'b1100011 || op == 7'b0010011 || op == 7'b1101111);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [6];
    logic [31:0] r;
    int k;
    ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
    ops[3] = 7'b1100011; ops[4] = 7'b0010011; ops[5] = 7'b1101111;
    r = $urandom();
    k = $urandom_range(0, 6);
    if (k < 6) r[6:0] = ops[k];
    return r;
  endfunction

  task automatic check_outputs();
    logic [63:0] e;
    if (!started) return;
    check("in_ready", 64'(in_ready), 64'(exp_q.size() != 2));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check("instr_o", 64'(instr_o), 64'(e[31:0]));
      check("pc_o", 64'(pc_o), 64'(e[63:32]));
      check("ctrl", 64'(dut_ctrl), 64'(ref_ctrl(e[31:0])));
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("illegal", 64'(illegal), 64'(ref_illegal(e[31:0])));
`endif
    end else if (after_reset) begin
      check("rst_instr_o", 64'(instr_o), 64'h13);
      check("rst_pc_o", 64'(pc_o), 64'h0);
      check("rst_ctrl", 64'(dut_ctrl), 64'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
      check("rst_illegal", 64'(illegal), 64'h0);
`endif
    end
  endtask

  // Driver: called just after a falling edge. Checks outputs, drives inputs
  // for the next rising edge, then advances the model across that edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic rn);
    bit rel, acc;
    check_outputs();
    if (started && out_valid && ordy) hs_cnt++;
    in_valid  = iv;
    instr_i   = ins;
    pc_i      = pc;
    out_ready = ordy;
    flush     = fl;
    reset_n   = rn;
    @(posedge clk);
    if (!rn) begin
      exp_q.delete();
      after_reset = 1'b1;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      rel = (exp_q.size() != 0) && ordy;
      acc = iv && (exp_q.size() != 2);
      if (rel) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back({pc, ins});
        after_reset = 1'b0;
      end
    end
    started = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] pc;
    @(negedge clk);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);

    // addi after reset, 1-cycle latency
    cycle(1, 32'h00A00093, 32'h0, 0, 0, 1);
    check("addi_valid", 64'(out_valid), 64'h1);
    check("addi_ctrl", 64'(dut_ctrl), 64'({2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10}));
    cycle(0, 0, 0, 1, 0, 1);

    // Stall: sw, beq fill the buffer, third input ignored
    cycle(1, 32'h00112223, 32'h4, 0, 0, 1);
    cycle(1, 32'hFE000EE3, 32'h8, 0, 0, 1);
    check("full_in_ready", 64'(in_ready), 64'h0);
    cycle(1, 32'h00000033, 32'hC, 0, 0, 1);
    check("sw_immsrc", 64'(immsrc), 64'h1);
    cycle(0, 0, 0, 1, 0, 1);
    check("beq_immsrc", 64'(immsrc), 64'h2);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);

    // 10 back-to-back with out_ready held high
    hs_cnt = 0;
    pc = 32'h100;
    for (int i = 0; i < 10; i++) begin
      cycle(1, rand_instr(), pc, 1, 0, 1);
      pc += 4;
    end
    cycle(0, 0, 0, 1, 0, 1);
    check("b2b_count", 64'(hs_cnt), 64'd10);

    // Flush in TWO with a same-cycle input
    cycle(1, 32'h00000063, 32'h200, 0, 0, 1);
    cycle(1, 32'h0000006F, 32'h204, 0, 0, 1);
    cycle(1, 32'h00000003, 32'h208, 0, 1, 1);
    check("flush_valid", 64'(out_valid), 64'h0);
    check("flush_in_ready", 64'(in_ready), 64'h1);
    cycle(0, 0, 0, 1, 0, 1);
    cycle(0, 0, 0, 1, 0, 1);

    // Unknown opcode decodes to no controls
    cycle(1, 32'h0000007F, 32'h300, 0, 0, 1);
    check("illop_ctrl", 64'(dut_ctrl), 64'h0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("illop_flag", 64'(illegal), 64'h1);
`endif
    cycle(0, 0, 0, 1, 0, 1);

    // Reset while in TWO
    cycle(1, 32'h00500113, 32'h400, 0, 0, 1);
    cycle(1, 32'h00208233, 32'h404, 0, 0, 1);
    cycle(0, 0, 0, 0, 0, 0);
    check("rst2_valid", 64'(out_valid), 64'h0);
    check("rst2_instr", 64'(instr_o), 64'h13);
    cycle(0, 0, 0, 1, 0, 1);

    // Random traffic
    pc = 32'h1000;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_instr(), pc,
            $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0,
            $urandom_range(0, 49) != 0);
      pc += 4;
    end
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
